// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// Produces one quotient bit per clock behind a start/busy/done handshake.
// Divide-by-zero skips the iterations and reports an all-ones quotient.
module seq_divider #(
    parameter int N_W   = 16,
    parameter int D_W   = 8,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [D_W:0]     prem;        // partial remainder, one bit wider than the divisor
    logic [N_W-1:0]   shreg;       // dividend bits out at the MSB, quotient bits in at the LSB
    logic [D_W-1:0]   dreg;

    logic [D_W:0]     shifted;
    logic [D_W+1:0]   trial;
    logic             trial_ok;
    logic [D_W:0]     prem_next;
    logic [N_W-1:0]   shreg_next;
    logic             last_iter;

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        shifted    = {prem[D_W-1:0], shreg[N_W-1]};
        trial      = {1'b0, shifted} - {2'b00, dreg};
        trial_ok   = ~trial[D_W+1];
        prem_next  = trial_ok ? trial[D_W:0] : shifted;
        shreg_next = {shreg[N_W-2:0], trial_ok};
        last_iter  = (cnt == CNT_W'(N_W - 1));
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prem        <= '0;
            shreg       <= '0;
            dreg        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        shreg <= dividend;
                        dreg  <= divisor;
                        cnt   <= '0;
                        prem  <= '0;
                        if (divisor != '0) begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end else begin
                            // No iterations needed: publish the divide-by-zero result directly.
                            state       <= FIN;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[D_W-1:0];
                            div_by_zero <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    prem  <= prem_next;
                    shreg <= shreg_next;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        state       <= FIN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= shreg_next;
                        remainder   <= prem_next[D_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
